axi4_slave_mem: RTL and testbench

//  AXI4 responder (slave) with internal word-addressed memory, the completion end for the AXI4 master in axi4_top.

---
 rtl/axi4_pkg.sv | 25 ++
 rtl/axi4_burst_addr.sv | 35 +++
 rtl/axi4_slave_mem.sv | 196 +++++++++++++++++++
 tb/tb_axi4_slave_mem.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared encodings for the AXI4 slave memory: burst and response codes, FSM states.
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axi4_burst_addr.sv
// Combinational AXI4 burst address step plus per-beat error classification.
module axi4_burst_addr #(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              oob,
  output logic              err
);
  import axi4_pkg::*;

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_mask;
  logic              wrap_len_ok;

  // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    step        = ADDR_W'(1) << size;
    wrap_mask   = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    oob         = (addr >> 2) >= ADDR_W'(MEM_WORDS);
    err         = oob || (size > 3'd2) || (burst == BURST_RSVD) ||
                  ((burst == BURST_WRAP) && !wrap_len_ok);
    case (burst)
      BURST_INCR: next_addr = (addr & ~(step - ADDR_W'(1))) + step;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 responder with an internal word memory; independent single-outstanding write and read bursts.
module axi4_slave_mem #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [7:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
);
  import axi4_pkg::*;

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  // ---------------- write path ----------------
  w_state_e          w_state, w_next;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len, w_cnt;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;
  logic              w_err;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_oob, w_beat_err;
  logic              aw_hs, w_hs, w_last;

  assign AWREADY = (w_state == W_IDLE);
  assign WREADY  = (w_state == W_DATA);
  assign BVALID  = (w_state == W_RESP);
  assign BRESP   = w_err ? RESP_SLVERR : RESP_OKAY;
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign w_last  = (w_cnt == aw_len);

  axi4_burst_addr #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) u_w_addr (
    .addr      (aw_addr),
    .len       (aw_len),
    .size      (aw_size),
    .burst     (aw_burst),
    .next_addr (w_next_addr),
    .oob       (w_oob),
    .err       (w_beat_err)
  );

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (AWVALID)         w_next = W_DATA;
      W_DATA:  if (w_hs && w_last)  w_next = W_RESP;
      W_RESP:  if (BREADY)          w_next = W_IDLE;
      default:                      w_next = W_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
      w_cnt    <= '0;
      w_err    <= 1'b0;
    end else if (aw_hs) begin
      aw_addr  <= AWADDR;
      aw_len   <= AWLEN;
      aw_size  <= AWSIZE;
      aw_burst <= AWBURST;
      w_cnt    <= '0;
      w_err    <= 1'b0;
    end else if (w_hs) begin
      aw_addr  <= w_next_addr;
      w_cnt    <= w_cnt + 8'd1;
      w_err    <= w_err | w_beat_err | (WLAST != w_last);
    end
  end

  // NOTE: the memory array has no reset; contents survive reset and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (reset && w_hs && !w_oob) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (WSTRB[lane]) mem[aw_addr[IDX_W+1:2]][8*lane +: 8] <= WDATA[8*lane +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_e          r_state, r_next;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [ADDR_W-1:0] ra_addr, r_next_addr;
  logic [7:0]        ra_len;
  logic [2:0]        ra_size;
  logic [1:0]        ra_burst;
  logic              r_oob, r_beat_err;
  logic              ar_hs, r_hs, r_load;

  assign ARREADY = (r_state == R_IDLE);
  assign RVALID  = (r_state == R_DATA);
  assign ar_hs   = ARVALID && ARREADY;
  assign r_hs    = RVALID && RREADY;
  assign r_load  = ar_hs || (r_hs && !RLAST);

  // r_addr holds the address of the next beat to fetch; while idle the AR channel feeds the unit.
  assign ra_addr  = (r_state == R_IDLE) ? ARADDR  : r_addr;
  assign ra_len   = (r_state == R_IDLE) ? ARLEN   : r_len;
  assign ra_size  = (r_state == R_IDLE) ? ARSIZE  : r_size;
  assign ra_burst = (r_state == R_IDLE) ? ARBURST : r_burst;

  axi4_burst_addr #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) u_r_addr (
    .addr      (ra_addr),
    .len       (ra_len),
    .size      (ra_size),
    .burst     (ra_burst),
    .next_addr (r_next_addr),
    .oob       (r_oob),
    .err       (r_beat_err)
  );

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ARVALID)         r_next = R_DATA;
      R_DATA:  if (RREADY && RLAST) r_next = R_IDLE;
      default:                      r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      RLAST   <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        r_len   <= ARLEN;
        r_size  <= ARSIZE;
        r_burst <= ARBURST;
        r_cnt   <= '0;
        RLAST   <= (ARLEN == 8'd0);
      end else if (r_hs) begin
        r_cnt   <= r_cnt + 8'd1;
        RLAST   <= !RLAST && ((r_cnt + 8'd1) == r_len);
      end
      // Registered read before any same-edge write lands: same-word collisions return old data.
      if (r_load) begin
        r_addr <= r_next_addr;
        RDATA  <= r_oob ? '0 : mem[ra_addr[IDX_W+1:2]];
        RRESP  <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed plus randomized bench for axi4_slave_mem against a word-array reference model.
module tb_axi4_slave_mem;

  localparam int MEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] AWADDR = '0;
  logic [7:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;

  axi4_slave_mem #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [MEM_WORDS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte address of beat i, derived from the burst rules as closed-form arithmetic.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input int size, input int burst, input int i);
    logic [31:0] step, total, lower;
    step  = 32'd1 << size;
    total = 32'(len + 1) * step;
    if (i == 0 || burst == 0 || burst == 3) return start;
    if (burst == 1) return (start & ~(step - 32'd1)) + 32'(i) * step;
    lower = (start / total) * total;
    return lower + ((start - lower) + 32'(i) * step) % total;
  endfunction

  function automatic bit burst_err(input int len, input int size, input int burst);
    return (size > 2) || (burst == 3) || (burst == 2 && !(len inside {1, 3, 7, 15}));
  endfunction

  function automatic bit is_oob(input logic [31:0] a);
    return (a >> 2) >= 32'(MEM_WORDS);
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len, input int size, input int burst,
                          input logic [31:0] dbase, input logic [3:0] strb, input bit rnd,
                          input int bad_last, input int b_stall);
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [31:0] exp_resp;
    bit          err_exp;
    int          t;
    err_exp = burst_err(len, size, burst);
    @(negedge clk);
    AWADDR = addr; AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst); AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 100) begin @(negedge clk); t++; end
    check("aw_ready", 32'(AWREADY), 32'd1);
    @(negedge clk);
    AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      d = rnd ? $urandom : dbase + 32'(i);
      s = rnd ? 4'($urandom) : strb;
      WDATA = d; WSTRB = s; WLAST = (i == len) ^ (i == bad_last); WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) check("w_ready_timeout", 32'(WREADY), 32'd1);
      @(negedge clk);
      if (is_oob(a) || (WLAST != (i == len))) err_exp = 1'b1;
      if (!is_oob(a)) begin
        for (int b = 0; b < 4; b++) if (s[b]) model[int'(a >> 2)][8*b +: 8] = d[8*b +: 8];
      end
    end
    WVALID = 1'b0; WLAST = 1'b0;
    exp_resp = err_exp ? 32'd2 : 32'd0;
    check("b_valid", 32'(BVALID), 32'd1);
    check("w_ready_off", 32'(WREADY), 32'd0);
    check("b_resp", 32'(BRESP), exp_resp);
    for (int k = 0; k < b_stall; k++) begin
      @(negedge clk);
      check("b_hold_valid", 32'(BVALID), 32'd1);
      check("b_hold_resp", 32'(BRESP), exp_resp);
    end
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    check("b_done", 32'(BVALID), 32'd0);
    check("aw_ready_back", 32'(AWREADY), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input int size, input int burst,
                         input int stall_beat, output logic [31:0] first);
    logic [31:0] a, exp_d, exp_r;
    int          t;
    first = '0;
    @(negedge clk);
    ARADDR = addr; ARLEN = 8'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
    ARVALID = 1'b1; RREADY = 1'b1;
    t = 0;
    while (!ARREADY && t < 100) begin @(negedge clk); t++; end
    check("ar_ready", 32'(ARREADY), 32'd1);
    @(negedge clk);
    ARVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      a     = beat_addr(addr, len, size, burst, i);
      exp_d = is_oob(a) ? 32'd0 : model[int'(a >> 2)];
      exp_r = (burst_err(len, size, burst) || is_oob(a)) ? 32'd2 : 32'd0;
      check("r_valid", 32'(RVALID), 32'd1);
      check("r_data", RDATA, exp_d);
      check("r_resp", 32'(RRESP), exp_r);
      check("r_last", 32'(RLAST), 32'(i == len));
      if (i == 0) first = RDATA;
      if (i == stall_beat) begin
        RREADY = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("r_hold_valid", 32'(RVALID), 32'd1);
          check("r_hold_data", RDATA, exp_d);
          check("r_hold_last", 32'(RLAST), 32'(i == len));
        end
        RREADY = 1'b1;
      end
      @(negedge clk);
    end
    RREADY = 1'b0;
    check("r_done", 32'(RVALID), 32'd0);
    check("ar_ready_back", 32'(ARREADY), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int          burst, size, len, stall;
    logic [31:0] addr;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(AWREADY), 32'd1);
    check("rst_arready", 32'(ARREADY), 32'd1);
    check("rst_wready", 32'(WREADY), 32'd0);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_rlast", 32'(RLAST), 32'd0);
    check("rst_bresp", 32'(BRESP), 32'd0);
    check("rst_rresp", 32'(RRESP), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    reset = 1'b1;

    // Fill the whole memory with one 256-beat burst, then read it all back.
    do_write(32'h0, 255, 2, 1, 32'h0, 4'hF, 1'b1, -1, 0);
    do_read(32'h0, 255, 2, 1, -1, rd);

    // Single FIXED beat
    do_write(32'h0, 0, 2, 0, 32'hDEADBEEF, 4'hF, 1'b0, -1, 0);
    do_read(32'h0, 0, 2, 0, -1, rd);
    check("fixed_data", rd, 32'hDEADBEEF);

    // INCR six beats, WRAP eight beats
    do_write(32'h4, 5, 2, 1, 32'h1000_0000, 4'hF, 1'b0, -1, 0);
    do_read(32'h4, 5, 2, 1, -1, rd);
    do_write(32'd48, 7, 2, 2, 32'h2000_0000, 4'hF, 1'b0, -1, 0);
    do_read(32'd48, 7, 2, 2, -1, rd);
    check("wrap_first", rd, 32'h2000_0000);

    // Backpressure on R and B
    do_read(32'h0, 7, 2, 1, 3, rd);
    do_write(32'h80, 3, 2, 1, 32'h3000_0000, 4'hF, 1'b0, -1, 3);

    // Out of range, then confirm no aliasing onto word 0
    do_write(32'(MEM_WORDS * 4), 0, 2, 1, 32'hBAD0BAD0, 4'hF, 1'b0, -1, 0);
    do_read(32'(MEM_WORDS * 4), 0, 2, 1, -1, rd);
    check("oob_rdata", rd, 32'd0);
    do_read(32'h0, 0, 2, 1, -1, rd);
    check("oob_no_alias", rd, 32'hDEADBEEF);

    // Byte strobes preserve unselected lanes
    do_write(32'h20, 0, 2, 1, 32'hFFFFFFFF, 4'hF, 1'b0, -1, 0);
    do_write(32'h20, 0, 2, 1, 32'h12345678, 4'h3, 1'b0, -1, 0);
    do_read(32'h20, 0, 2, 1, -1, rd);
    check("strb_merge", rd, 32'hFFFF5678);

    // Protocol errors: reserved burst, oversize beat, early and missing WLAST
    do_write(32'h40, 0, 2, 3, 32'h4000_0000, 4'hF, 1'b0, -1, 0);
    do_read(32'h8, 0, 3, 1, -1, rd);
    do_write(32'h100, 1, 2, 1, 32'h5000_0000, 4'hF, 1'b0, 0, 0);
    do_write(32'h110, 2, 2, 1, 32'h6000_0000, 4'hF, 1'b0, 2, 0);
    do_read(32'h100, 5, 2, 1, -1, rd);

    // Reset in the middle of an 8-beat read
    @(negedge clk);
    ARADDR = 32'h0; ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = 2'd1; ARVALID = 1'b1; RREADY = 1'b1;
    @(negedge clk);
    ARVALID = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_beat3", RDATA, model[3]);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_rvalid", 32'(RVALID), 32'd0);
    check("mid_rst_arready", 32'(ARREADY), 32'd1);
    reset = 1'b1; RREADY = 1'b0;
    do_read(32'h0, 7, 2, 1, -1, rd);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      burst = $urandom_range(0, 2);
      size  = $urandom_range(0, 2);
      len   = (burst == 2) ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 15);
      addr  = 32'($urandom_range(0, MEM_WORDS * 4 + 63));
      stall = $urandom_range(0, 1) ? $urandom_range(0, len) : -1;
      if ($urandom_range(0, 1) == 1)
        do_write(addr, len, size, burst, 32'h0, 4'hF, 1'b1, -1, stall < 0 ? 0 : 2);
      else
        do_read(addr, len, size, burst, stall, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
